// File: rtl/note_lanes.sv
// Falling-note tracker: DEPTH slots of (y, lane mask), tick-driven movement, hit/miss detection, per-lane sprite render.
// Latency: sprite_pattern is combinational; hit/miss/count update one cycle after the triggering edge; tick is a decode of the divider.
// Backpressure: spawn_ready drops when every slot is valid; spawns while full or with an empty mask are dropped.
module note_lanes #(
  parameter int LANES    = 4,
  parameter int DEPTH    = 8,
  parameter int X_W      = 10,
  parameter int Y_W      = 10,
  parameter int LANE_W   = 160,
  parameter int HALF_H   = 8,
  parameter int TICK_DIV = 800000,
  parameter int STEP     = 1,
  parameter int SCREEN_H = 480,
  parameter int HIT_Y    = 440,
  parameter int HIT_WIN  = 16
) (
  input  logic                         CLOCK_24,
  input  logic                         reset,
  input  logic                         spawn_valid,
  input  logic [LANES-1:0]             spawn_mask,
  input  logic [Y_W-1:0]               spawn_y,
  output logic                         spawn_ready,
  input  logic [LANES-1:0]             press,
  input  logic [X_W-1:0]               next_x,
  input  logic [Y_W-1:0]               next_y,
  output logic [LANES-1:0]             sprite_pattern,
  output logic [LANES-1:0]             hit,
  output logic [LANES-1:0]             miss,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         tick
);

  // One extra bit on y arithmetic so sums near the screen edges never wrap.
  localparam int YE_W  = Y_W + 1;
  localparam int TC_W  = $clog2(TICK_DIV + 1);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [YE_W-1:0] MISS_Y    = YE_W'(SCREEN_H + HALF_H);
  localparam logic [YE_W-1:0] WIN_LO    = YE_W'((HIT_Y > HIT_WIN) ? (HIT_Y - HIT_WIN) : 0);
  localparam logic [YE_W-1:0] WIN_HI    = YE_W'(HIT_Y + HIT_WIN);
  localparam logic [YE_W-1:0] STEP_E    = YE_W'(STEP);
  localparam logic [YE_W-1:0] HALF_E    = YE_W'(HALF_H);
  localparam logic [TC_W-1:0] TICK_LAST = TC_W'(TICK_DIV - 1);

  // Slot storage and registered outputs
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [Y_W-1:0]   y_q    [DEPTH];
  logic [Y_W-1:0]   y_d    [DEPTH];
  logic [LANES-1:0] mask_q [DEPTH];
  logic [LANES-1:0] mask_d [DEPTH];
  logic [TC_W-1:0]  tick_cnt_q, tick_cnt_d;
  logic [LANES-1:0] hit_q, hit_d;
  logic [LANES-1:0] miss_q, miss_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Derived per-slot / per-lane values
  logic [YE_W-1:0]  y_adv    [DEPTH];
  logic [DEPTH-1:0] in_win;
  logic [LANES-1:0] cand_vld;
  logic [IDX_W-1:0] cand_idx [LANES];
  logic [Y_W-1:0]   cand_y   [LANES];
  logic [LANES-1:0] hit_lane;
  logic [LANES-1:0] hit_clr  [DEPTH];
  logic [IDX_W-1:0] free_idx;
  logic             spawn_ok;
  logic [LANES-1:0] lane_on;

  assign tick        = (tick_cnt_q == TICK_LAST);
  assign spawn_ready = ~&valid_q;
  assign spawn_ok    = spawn_valid && spawn_ready && (|spawn_mask);
  assign hit         = hit_q;
  assign miss        = miss_q;
  assign count       = count_q;

  // Per-slot advanced y and hit-window membership, both from pre-tick y
  always_comb begin
    for (int s = 0; s < DEPTH; s++) begin
      y_adv[s]  = {1'b0, y_q[s]} + STEP_E;
      in_win[s] = ({1'b0, y_q[s]} >= WIN_LO) && ({1'b0, y_q[s]} <= WIN_HI);
    end
  end

  // Per lane, pick the eligible slot lowest on screen; strict compare keeps the lowest index on ties
  always_comb begin
    cand_vld = '0;
    for (int l = 0; l < LANES; l++) begin
      cand_idx[l] = '0;
      cand_y[l]   = '0;
    end
    for (int l = 0; l < LANES; l++) begin
      for (int s = 0; s < DEPTH; s++) begin
        if (valid_q[s] && mask_q[s][l] && in_win[s] && (!cand_vld[l] || (y_q[s] > cand_y[l]))) begin
          cand_vld[l] = 1'b1;
          cand_idx[l] = IDX_W'(s);
          cand_y[l]   = y_q[s];
        end
      end
    end
  end

  // Translate per-lane winners into per-slot mask bits to clear
  always_comb begin
    hit_lane = press & cand_vld;
    for (int s = 0; s < DEPTH; s++) begin
      for (int l = 0; l < LANES; l++) begin
        hit_clr[s][l] = hit_lane[l] && (cand_idx[l] == IDX_W'(s));
      end
    end
  end

  // Lowest-index free slot, judged on valid bits at the start of the cycle
  always_comb begin
    free_idx = '0;
    for (int s = DEPTH - 1; s >= 0; s--) begin
      if (!valid_q[s]) free_idx = IDX_W'(s);
    end
  end

  // Next state: hits first, then movement/miss on tick, then spawn into a slot free at cycle start
  always_comb begin
    tick_cnt_d = tick ? '0 : tick_cnt_q + TC_W'(1);
    valid_d    = valid_q;
    hit_d      = hit_lane;
    miss_d     = '0;
    count_d    = '0;
    for (int s = 0; s < DEPTH; s++) begin
      y_d[s]    = y_q[s];
      mask_d[s] = mask_q[s];
      if (valid_q[s]) begin
        mask_d[s] = mask_q[s] & ~hit_clr[s];
        if (mask_d[s] == '0) begin
          valid_d[s] = 1'b0;
        end else if (tick) begin
          y_d[s] = y_adv[s][Y_W-1:0];
          if (y_adv[s] >= MISS_Y) begin
            valid_d[s] = 1'b0;
            miss_d     = miss_d | mask_d[s];
          end
        end
      end
    end
    if (spawn_ok) begin
      valid_d[free_idx] = 1'b1;
      y_d[free_idx]     = spawn_y;
      mask_d[free_idx]  = spawn_mask;
    end
    for (int s = 0; s < DEPTH; s++) begin
      count_d = count_d + CNT_W'(valid_d[s]);
    end
  end

  // State register; reset drops every note and any pending pulse
  always_ff @(posedge CLOCK_24 or posedge reset) begin
    if (reset) begin
      valid_q    <= '0;
      tick_cnt_q <= '0;
      hit_q      <= '0;
      miss_q     <= '0;
      count_q    <= '0;
      for (int s = 0; s < DEPTH; s++) begin
        y_q[s]    <= '0;
        mask_q[s] <= '0;
      end
    end else begin
      valid_q    <= valid_d;
      tick_cnt_q <= tick_cnt_d;
      hit_q      <= hit_d;
      miss_q     <= miss_d;
      count_q    <= count_d;
      for (int s = 0; s < DEPTH; s++) begin
        y_q[s]    <= y_d[s];
        mask_q[s] <= mask_d[s];
      end
    end
  end

  // Which lane column the queried pixel x falls in
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      lane_on[l] = (32'(next_x) >= 32'($unsigned(l * LANE_W))) &&
                   (32'(next_x) <  32'($unsigned((l + 1) * LANE_W)));
    end
  end

  // Sprite render: pixel within HALF_H of a note's y in its lane
  always_comb begin
    sprite_pattern = '0;
    for (int l = 0; l < LANES; l++) begin
      for (int s = 0; s < DEPTH; s++) begin
        if (valid_q[s] && mask_q[s][l] && lane_on[l] &&
            (({1'b0, next_y} + HALF_E) >= {1'b0, y_q[s]}) &&
            ({1'b0, next_y} < ({1'b0, y_q[s]} + HALF_E))) begin
          sprite_pattern[l] = 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/note_lanes.md
Name: note_lanes

Overview:
- Parametrised successor to the single-note falling sprite generator for the rhythm-game screen.
- Holds up to DEPTH falling notes in flight. Each note is a y position plus a lane mask across LANES vertical lanes.
- Advances all notes on a programmable tick and renders per-lane sprite bits for the VGA pixel query.
- Detects hits (press inside a window around HIT_Y) and misses (note leaves the screen). Sits between the song sequencer (spawn side) and the VGA/score logic in top.

Parameters:
- LANES, 4, number of lanes/colours.
- DEPTH, 8, max simultaneous notes (slots).
- X_W, 10, width of pixel x.
- Y_W, 10, width of note/pixel y.
- LANE_W, 160, lane width in pixels; lane l spans x in [l*LANE_W, (l+1)*LANE_W).
- HALF_H, 8, half sprite height; sprite covers y-HALF_H <= py < y+HALF_H.
- TICK_DIV, 800000, clocks per movement tick.
- STEP, 1, pixels advanced per tick.
- SCREEN_H, 480, visible height.
- HIT_Y, 440, hit line y.
- HIT_WIN, 16, hit accepted when |y-HIT_Y| <= HIT_WIN.

Ports:
- CLOCK_24  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- spawn_valid  in  1  request to insert a note.
- spawn_mask  in  LANES  lanes the new note occupies.
- spawn_y  in  Y_W  initial y of the new note.
- spawn_ready  out  1  high when at least one slot is free.
- press  in  LANES  one-cycle key-press pulses, one per lane.
- next_x  in  X_W  pixel x being drawn.
- next_y  in  Y_W  pixel y being drawn.
- sprite_pattern  out  LANES  combinational; bit l set if pixel lies on a lane-l note.
- hit  out  LANES  registered one-cycle pulse per lane hit.
- miss  out  LANES  registered one-cycle pulse per lane missed.
- count  out  clog2(DEPTH+1)  number of valid slots.
- tick  out  1  one-cycle pulse on the cycle notes advance.

Behaviour:
- Reset (async): all slot valid bits 0; tick counter 0; hit, miss, tick, count = 0; spawn_ready = 1. sprite_pattern is therefore 0.
- Slot storage: valid, y[Y_W-1:0], mask[LANES-1:0] per slot.
- Tick counter: counts 0..TICK_DIV-1. tick=1 during the cycle the counter equals TICK_DIV-1; the counter wraps to 0 at that edge.
- Movement: on the tick edge every valid slot takes y <= y+STEP.
- Miss: at the tick edge, any slot whose new y >= SCREEN_H+HALF_H is freed. miss pulses the OR of those slots' remaining masks in the next cycle.
- Spawn: accepted when spawn_valid && spawn_ready && spawn_mask != 0. The note is written into the lowest-index free slot (by valid bits at cycle start). No tick advance applies to the new note in its spawn cycle.
  - spawn_valid with spawn_mask == 0 is dropped.
  - spawn while full is dropped, count unchanged.
- spawn_ready = ~&valid (registered state, no combinational path from spawn_valid).
- Hit, evaluated per lane l when press[l]=1, using pre-tick y values:
  - Eligible slot: valid, mask[l]=1, and HIT_Y-HIT_WIN <= y <= HIT_Y+HIT_WIN (compare in Y_W+1 bits, no wrap).
  - Chosen slot: the eligible slot with the largest y; ties go to the lowest index.
  - Effect: clear mask[l] in the chosen slot and pulse hit[l] next cycle. A slot whose mask becomes 0 is freed.
  - Multiple lanes pressed in one cycle are resolved independently; several may clear bits in the same slot.
  - Press with no eligible slot: no effect, no pulse.
- Simultaneous events:
  - Hit and miss on the same slot in one cycle: hit wins for hit lanes; miss reports only the remaining bits.
  - Slots freed this cycle are reusable by spawn next cycle, not this one.
- count reflects valid bits after the edge (registered popcount).
- Render (combinational, zero latency):
  - sprite_pattern[l] = OR over slots of valid && mask[l] && next_x in lane l && next_y+HALF_H >= y && next_y < y+HALF_H.
  - Arithmetic is in Y_W+1 bits, so notes with y < HALF_H render correctly at the top edge without wrap.
- Mid-operation reset drops all notes immediately; no pending hit/miss pulse is emitted.

Test Plan:
- Bench overrides TICK_DIV=4. Spawn mask=0001, y=0; run 40 clocks -> y=10, tick pulsed 10 times; (x=5,y=3) -> pattern 0001; (x=165,y=3) -> 0000; (x=5,y=18) -> 0000; (x=5,y=2) with note y=2 -> 0001 (top-edge, no wrap).
- Spawn 8 notes -> count=8, spawn_ready=0; 9th spawn ignored, count stays 8; one miss frees a slot -> spawn_ready=1 the cycle after.
- Note y=440 mask=0011: press 0001 -> hit=0001 one cycle later, count unchanged, lane 1 still drawn. Press 0010 -> hit=0010, count decrements by 1.
- Lane 0 notes at y=430 and y=450, press 0001 -> only y=450 removed. Note at y=300, press 0001 -> no hit.
- Spawn y=487 mask=1000 -> at the next tick miss=1000 pulses one cycle, count=0. Same setup with press 1000 at y=440 -> hit, no miss.
- Three notes active, assert reset for 1 cycle asynchronously -> count=0, sprite_pattern=0, hit=miss=0, spawn_ready=1. Subsequent spawn lands in slot 0.
